serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit period; legal values are integers >= 4.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 The block SHALL have port data  output  8  last correctly received byte.
REQ-006 The block SHALL have port valid  output  1  one-cycle pulse marking a new byte on data.
REQ-007 The block SHALL have port frame_err  output  1  one-cycle pulse marking a stop-bit error.
REQ-008 The block SHALL have port busy  output  1  high whenever the state machine is not in IDLE.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer (rx_s), with both flops resetting to 1; rx_s lags rx by 2 cycles.
REQ-010 The block SHALL use states IDLE, START, DATA, STOP and WAIT_HIGH, plus a cycle counter and a 3-bit bit index.
REQ-011 In IDLE, the first cycle with rx_s=0 (T0) SHALL move to START with the counter cleared.
REQ-012 In START, at T0+CLKS_PER_BIT/2 (integer division), rx_s SHALL be sampled: 0 goes to DATA with bit index 0; 1 is a false start and returns to IDLE with no pulse.
REQ-013 In DATA, bit i (i=0..7) SHALL be sampled at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into shift position i (LSB first); after bit 7 the state goes to STOP.
REQ-014 In STOP, rx_s SHALL be sampled at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-015 If the stop sample is 1: next cycle data loads the assembled byte, valid=1 for exactly that cycle, and the state returns to IDLE.
REQ-016 If the stop sample is 0: next cycle frame_err=1 for exactly that cycle, data is unchanged, and the state goes to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL return to IDLE on the first cycle with rx_s=1; no start is detected while in WAIT_HIGH.
REQ-018 A start edge SHALL be detectable on the first cycle back in IDLE, so back-to-back frames with a single stop bit are received without loss.
REQ-019 valid and frame_err SHALL never be high in the same cycle; data SHALL change only together with valid.
REQ-020 Line changes between sample points SHALL be ignored; there is no majority voting.
REQ-021 busy SHALL be 1 in START, DATA, STOP and WAIT_HIGH, and 0 in IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, data=8'h00, valid=0, frame_err=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; after release, reception restarts only on a new falling edge of rx_s.
REQ-024 Reset release SHALL be treated as synchronous to clk by the surrounding system; the block adds no reset synchronizer.

Verification
REQ-025 CLKS_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> valid pulses once at T0+153 with data=8'hA5; frame_err stays 0; busy drops the same cycle.
REQ-026 Drive rx low for 4 cycles, then high -> START aborts at T0+8; valid=0, frame_err=0, data unchanged, busy high for 8 cycles.
REQ-027 Send 0x3C with stop bit 0, held low 40 cycles -> frame_err pulses once at T0+153, data keeps its previous value, busy stays 1 until 1 cycle after rx_s returns high.
REQ-028 Send 0x00 then 0xFF back-to-back, 1 stop bit each -> two valid pulses exactly 160 cycles apart with data 8'h00 then 8'hFF.
REQ-029 Assert rst_n=0 during bit 4 of 0x5A, release, then send 0x81 -> no pulse for 0x5A; data=8'h00 until valid with data=8'h81.
REQ-030 Run with CLKS_PER_BIT=5 and a random byte stream of 200 frames -> every byte matches, and there are zero frame_err pulses.

Source files
------------

// File: rtl/serial_rx_if.sv
// Serial receiver bus: the line input plus the received-byte outputs.
// The slave modport is the receiver's side; the master modport is the line driver and observer.
interface serial_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: synchronizes rx, times samples from the start-bit edge, and
// emits single-cycle valid / frame_err pulses.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_rx_if.slave  rx_bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx_bus.rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The counter is cleared at every sample point, so each stage only
    // counts its own interval since the previous sample.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_bus.data      = data_q;
    assign rx_bus.valid     = valid_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: a 16-clock receiver for the framing and timing cases,
// and a 5-clock receiver for a back-to-back random byte stream.
module tb_serial_rx;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_rx_if ifa ();
    serial_rx_if ifb ();

    serial_rx #(.CLKS_PER_BIT(16)) dut_a (.clk(clk), .rst_n(rst_n), .rx_bus(ifa));
    serial_rx #(.CLKS_PER_BIT(5))  dut_b (.clk(clk), .rst_n(rst_n), .rx_bus(ifb));

    // Monitors record pulse timing and bus invariants at the falling edge.
    int         va_cnt, fe_cnt, va_cyc, fe_cyc, bf_cyc, br_cyc, viol;
    int         vq_cyc[$];
    logic [7:0] vq_data[$];
    logic [7:0] prev_data_a = 8'h00;
    logic       prev_busy_a = 1'b0;
    int         vb_cnt, feb_cnt;
    logic [7:0] bq[$];
    logic [7:0] prev_data_b = 8'h00;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ifa.valid === 1'b1) begin
                va_cnt++;
                va_cyc = cyc;
                vq_cyc.push_back(cyc);
                vq_data.push_back(ifa.data);
            end
            if (ifa.frame_err === 1'b1) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (ifa.valid === 1'b1 && ifa.frame_err === 1'b1) viol++;
            if (ifa.data !== prev_data_a && ifa.valid !== 1'b1) viol++;
            if (prev_busy_a && ifa.busy === 1'b0) bf_cyc = cyc;
            if (!prev_busy_a && ifa.busy === 1'b1) br_cyc = cyc;
            if (ifb.valid === 1'b1) begin
                vb_cnt++;
                bq.push_back(ifb.data);
            end
            if (ifb.frame_err === 1'b1) feb_cnt++;
            if (ifb.valid === 1'b1 && ifb.frame_err === 1'b1) viol++;
            if (ifb.data !== prev_data_b && ifb.valid !== 1'b1) viol++;
        end
        prev_data_a = ifa.data;
        prev_busy_a = (ifa.busy === 1'b1);
        prev_data_b = ifb.data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) ifb.rx = v;
        else     ifa.rx = v;
    endtask

    task automatic clear_mon();
        va_cnt = 0; fe_cnt = 0; va_cyc = -1; fe_cyc = -1; bf_cyc = -1; br_cyc = -1;
        vb_cnt = 0; feb_cnt = 0;
        vq_cyc.delete(); vq_data.delete(); bq.delete();
    endtask

    // Called just after a rising edge; returns the cycle the start bit was driven
    // and the cycle the line was returned high after the stop bit.
    task automatic send_frame(input bit sel, input int cpb, input logic [7:0] b,
                              input logic stop_v, input int stop_len,
                              output int t_start, output int t_rise);
        set_rx(sel, 1'b0);
        t_start = cyc;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            tick(cpb);
        end
        set_rx(sel, stop_v);
        tick(stop_len);
        set_rx(sel, 1'b1);
        t_rise = cyc;
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         stop_len;
        int         exp_valid;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[5];
    int         s, r, s2, r2;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 40, 0, 1, 8'hA5};
        vecs[2] = '{8'h01, 1'b1, 16, 1, 0, 8'h01};
        vecs[3] = '{8'h80, 1'b0, 40, 0, 1, 8'h01};
        vecs[4] = '{8'h7E, 1'b1, 16, 1, 0, 8'h7E};

        rst_n  = 1'b0;
        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        clear_mon();
        viol = 0;
        tick(2);
        chk("reset_data",  32'(ifa.data), 32'h00);
        chk("reset_valid", 32'(ifa.valid), 32'h0);
        chk("reset_ferr",  32'(ifa.frame_err), 32'h0);
        chk("reset_busy",  32'(ifa.busy), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            send_frame(1'b0, 16, vecs[v].byte_v, vecs[v].stop_v, vecs[v].stop_len, s, r);
            tick(20);
            chk($sformatf("vec%0d_valid_cnt", v), 32'(va_cnt), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_ferr_cnt", v),  32'(fe_cnt), 32'(vecs[v].exp_fe));
            chk($sformatf("vec%0d_data", v),      32'(ifa.data), 32'(vecs[v].exp_data));
            if (vecs[v].exp_valid == 1) begin
                chk($sformatf("vec%0d_valid_cycle", v), 32'(va_cyc - s), 32'd155);
                chk($sformatf("vec%0d_busy_fall", v),   32'(bf_cyc - s), 32'd155);
            end else begin
                chk($sformatf("vec%0d_ferr_cycle", v), 32'(fe_cyc - s), 32'd155);
                chk($sformatf("vec%0d_busy_fall", v),  32'(bf_cyc - r), 32'd3);
            end
        end

        // False start: line low for 4 cycles only.
        clear_mon();
        set_rx(1'b0, 1'b0);
        s = cyc;
        tick(4);
        set_rx(1'b0, 1'b1);
        tick(20);
        chk("false_busy_rise", 32'(br_cyc - s), 32'd3);
        chk("false_busy_fall", 32'(bf_cyc - s), 32'd11);
        chk("false_valid_cnt", 32'(va_cnt), 32'd0);
        chk("false_ferr_cnt",  32'(fe_cnt), 32'd0);
        chk("false_data",      32'(ifa.data), 32'h7E);

        // Back-to-back frames with a single stop bit each.
        clear_mon();
        send_frame(1'b0, 16, 8'h00, 1'b1, 16, s, r);
        send_frame(1'b0, 16, 8'hFF, 1'b1, 16, s2, r2);
        tick(20);
        chk("b2b_count", 32'(vq_cyc.size()), 32'd2);
        if (vq_cyc.size() == 2) begin
            chk("b2b_first_cycle", 32'(vq_cyc[0] - s), 32'd155);
            chk("b2b_spacing",     32'(vq_cyc[1] - vq_cyc[0]), 32'd160);
            chk("b2b_data0",       32'(vq_data[0]), 32'h00);
            chk("b2b_data1",       32'(vq_data[1]), 32'hFF);
        end

        // Reset in the middle of bit 4 of 0x5A.
        clear_mon();
        b = 8'h5A;
        set_rx(1'b0, 1'b0);
        tick(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(1'b0, b[i]);
            tick(16);
        end
        set_rx(1'b0, b[4]);
        tick(8);
        rst_n = 1'b0;
        #1;
        chk("midrst_async_data", 32'(ifa.data), 32'h00);
        chk("midrst_async_busy", 32'(ifa.busy), 32'h0);
        set_rx(1'b0, 1'b1);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("midrst_valid_cnt", 32'(va_cnt), 32'd0);
        chk("midrst_ferr_cnt",  32'(fe_cnt), 32'd0);
        chk("midrst_data_idle", 32'(ifa.data), 32'h00);
        send_frame(1'b0, 16, 8'h81, 1'b1, 16, s, r);
        tick(20);
        chk("midrst_next_cnt",   32'(va_cnt), 32'd1);
        chk("midrst_next_data",  32'(ifa.data), 32'h81);
        chk("midrst_next_cycle", 32'(va_cyc - s), 32'd155);

        // Random back-to-back stream at 5 clocks per bit.
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(1'b1, 5, b, 1'b1, 5, s, r);
        end
        tick(20);
        chk("stream_count", 32'(vb_cnt), 32'd200);
        chk("stream_ferr",  32'(feb_cnt), 32'd0);
        for (int k = 0; k < 200; k++) begin
            if (k < bq.size()) chk($sformatf("stream_byte%0d", k), 32'(bq[k]), 32'(exp_q[k]));
        end

        chk("invariant_violations", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
